encoder_8to3_seq: RTL and testbench
===================================

Name: encoder_8to3_seq

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's active-low 3-to-8 decoder.
- Samples an 8-bit active-low line vector (Y7..Y0 form) and captures every asserted line into a pending mask.
- Emits the 3-bit index {A,B,C} of each pending line, one per valid/ready transfer, in fixed priority order.
- Sits on the return path after decoded select lines and turns them back into binary codes for downstream logic. Also flags non-one-hot input.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = serve highest index first (7..0), 0 = lowest first (0..7).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous, active-high.
- Y_n  input  8  active-low line vector; bit i low = line i asserted; Y_n[7] = Y7.
- en  input  1  capture enable, sampled only in IDLE.
- ready  input  1  downstream accepts the current index.
- A  output  1  index MSB (registered).
- B  output  1  index middle bit (registered).
- C  output  1  index LSB (registered).
- valid  output  1  {A,B,C} holds a pending index.
- multi  output  1  last capture had more than one line asserted (sticky until next capture).
- pend_cnt  output  4  number of lines still pending, 0..8.
- busy  output  1  state is SERVE.

Behaviour:
- Reset, async, while rst=1: state IDLE; pending mask 8'h00; A=B=C=0; valid=0; multi=0; pend_cnt=0; busy=0. Reset mid-SERVE discards all pending lines.
- States: IDLE and SERVE.
- IDLE, with en=1 and ~Y_n != 0 at the clock edge:
  - mask <= ~Y_n; pend_cnt <= popcount(~Y_n).
  - multi <= (popcount > 1).
  - {A,B,C} <= priority index of ~Y_n; valid <= 1; busy <= 1; go to SERVE.
  - Latency: capture edge to valid high is 1 cycle.
- IDLE, with en=0 or Y_n=8'hFF: no change. multi keeps its value. valid stays 0.
- SERVE, transfer (valid=1 and ready=1 at the edge):
  - Clear the mask bit of the current index; pend_cnt decrements.
  - More bits remain: {A,B,C} <= next priority index and valid stays 1, so back-to-back transfers have no bubble.
  - Last bit: valid <= 0; busy <= 0; {A,B,C} hold their last value; go to IDLE.
- SERVE, ready=0: all outputs hold.
- Y_n and en are ignored in SERVE. Lines asserted during SERVE are not merged; they are seen only if still asserted in a later IDLE cycle.
- Minimum gap between the last transfer and the next capture: 1 IDLE cycle, so valid is low for at least 1 cycle.
- Priority index: HIGH_FIRST=1 picks the largest set bit, HIGH_FIRST=0 the smallest. Encoding is binary, A = bit2.
- pend_cnt is always equal to popcount(mask). It is 8 when all lines are captured, so it is 4 bits wide.

Test Plan:
- Reset then single line: rst pulse; en=1, Y_n=8'hFB (line 2) -> next cycle valid=1, {A,B,C}=3'b010, multi=0, pend_cnt=1; ready=1 -> next cycle valid=0, busy=0, pend_cnt=0.
- Multi-line with HIGH_FIRST=1: Y_n=8'h5A (lines 7,5,2,0), ready held 1 -> valid held high for 4 consecutive cycles, indices 7,5,2,0; multi=1; pend_cnt steps 4,3,2,1; then valid=0. Repeat with HIGH_FIRST=0 -> indices 0,2,5,7.
- Backpressure: Y_n=8'h00 (all 8 lines), ready=0 for 5 cycles -> {A,B,C}=3'b111, pend_cnt=8, all outputs stable; then ready=1 -> indices 7..0, one per cycle.
- Enable and idle input: en=0 with Y_n=8'h00 -> valid stays 0. en=1 with Y_n=8'hFF -> valid stays 0 and multi keeps its prior value.
- Inputs ignored in SERVE: capture Y_n=8'hF7 (line 3), hold ready=0 and change Y_n to 8'hFE -> only index 3 is served. Line 0, still held, is captured in the first IDLE cycle after the transfer: valid low for exactly 1 cycle, then index 0.
- Async reset mid-SERVE: capture 8'h5A, complete 1 transfer, assert rst between clock edges -> valid=0, pend_cnt=0, multi=0 immediately; no further indices after rst is released with Y_n=8'hFF.

Source files
------------

// File: rtl/encoder_8to3_seq_if.sv
// rtl/encoder_8to3_seq_if.sv - line vector in, encoded index stream and status out
interface encoder_8to3_seq_if;
    logic [7:0] Y_n;
    logic       en;
    logic       ready;
    logic       A;
    logic       B;
    logic       C;
    logic       valid;
    logic       multi;
    logic [3:0] pend_cnt;
    logic       busy;

    modport master (
        output Y_n, en, ready,
        input  A, B, C, valid, multi, pend_cnt, busy
    );

    modport slave (
        input  Y_n, en, ready,
        output A, B, C, valid, multi, pend_cnt, busy
    );
endinterface

// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - captures active-low lines and emits their indices in priority order
module encoder_8to3_seq #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    encoder_8to3_seq_if.slave   bus
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t     state, state_nxt;
    logic [7:0] mask, mask_nxt;
    logic [2:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       valid, valid_nxt;
    logic       multi, multi_nxt;
    logic [7:0] lines;
    logic [7:0] rem;
    logic [3:0] lines_cnt;

    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) r = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) r = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    assign lines     = ~bus.Y_n;
    assign lines_cnt = popcount(lines);
    assign rem       = mask & ~(8'b1 << idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mask  <= 8'h00;
            idx   <= 3'd0;
            cnt   <= 4'd0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            valid <= valid_nxt;
            multi <= multi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        valid_nxt = valid;
        multi_nxt = multi;
        case (state)
            IDLE: begin
                if (bus.en && (lines != 8'h00)) begin
                    mask_nxt  = lines;
                    cnt_nxt   = lines_cnt;
                    multi_nxt = (lines_cnt > 4'd1);
                    idx_nxt   = pick(lines);
                    valid_nxt = 1'b1;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                // The index register keeps its last value on exit so A/B/C hold.
                if (valid && bus.ready) begin
                    mask_nxt = rem;
                    cnt_nxt  = cnt - 4'd1;
                    if (rem != 8'h00) begin
                        idx_nxt = pick(rem);
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.A        = idx[2];
    assign bus.B        = idx[1];
    assign bus.C        = idx[0];
    assign bus.valid    = valid;
    assign bus.multi    = multi;
    assign bus.pend_cnt = cnt;
    assign bus.busy     = (state == SERVE);

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - scoreboard bench running both priority orders side by side
module tb_encoder_8to3_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [6:0] qh[$];
    logic [6:0] ql[$];

    encoder_8to3_seq_if bh();
    encoder_8to3_seq_if bl();

    encoder_8to3_seq #(.HIGH_FIRST(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(bh));
    encoder_8to3_seq #(.HIGH_FIRST(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(bl));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [7:0] y, input logic e, input logic r);
        bh.Y_n = y;   bl.Y_n = y;
        bh.en = e;    bl.en = e;
        bh.ready = r; bl.ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected transfer order per instance: {index, pending count before the transfer}.
    task automatic push_exp(input logic [7:0] lines);
        int n;
        int left;
        n = 0;
        for (int k = 0; k < 8; k++) if (lines[k]) n++;
        left = n;
        for (int k = 7; k >= 0; k--) begin
            if (lines[k]) begin
                qh.push_back({3'(k), 4'(left)});
                left--;
            end
        end
        left = n;
        for (int k = 0; k < 8; k++) begin
            if (lines[k]) begin
                ql.push_back({3'(k), 4'(left)});
                left--;
            end
        end
    endtask

    task automatic capture(input logic [7:0] lines, input logic r);
        set_in(~lines, 1'b1, r);
        push_exp(lines);
        step();
        set_in(8'hFF, 1'b0, r);
    endtask

    task automatic serve_check(input int n);
        for (int k = 0; k < n; k++) begin
            chk("serve_valid_h", 16'(bh.valid), 16'd1);
            chk("serve_valid_l", 16'(bl.valid), 16'd1);
            step();
        end
        chk("serve_end_h", 16'(bh.valid), 16'd0);
        chk("serve_end_l", 16'(bl.valid), 16'd0);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((qh.size() != 0 || ql.size() != 0 || bh.valid || bl.valid) && cyc < 40) begin
            step();
            cyc++;
        end
        chk("drain_timeout", 16'(cyc < 40), 16'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && bh.valid && bh.ready) begin
            if (qh.size() == 0) chk("sb_h_extra", {9'd0, bh.A, bh.B, bh.C, bh.pend_cnt}, 16'h7F);
            else chk("sb_h_idx", {9'd0, bh.A, bh.B, bh.C, bh.pend_cnt}, {9'd0, qh.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && bl.valid && bl.ready) begin
            if (ql.size() == 0) chk("sb_l_extra", {9'd0, bl.A, bl.B, bl.C, bl.pend_cnt}, 16'h7F);
            else chk("sb_l_idx", {9'd0, bl.A, bl.B, bl.C, bl.pend_cnt}, {9'd0, ql.pop_front()});
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_in(8'hFF, 1'b0, 1'b0);
        #1;
        chk("rst_abc", {13'd0, bh.A, bh.B, bh.C}, 16'd0);
        chk("rst_valid", 16'(bh.valid), 16'd0);
        chk("rst_multi", 16'(bh.multi), 16'd0);
        chk("rst_pend", 16'(bh.pend_cnt), 16'd0);
        chk("rst_busy", 16'(bh.busy), 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // single line 2
        capture(8'h04, 1'b1);
        chk("single_valid", 16'(bh.valid), 16'd1);
        chk("single_abc", {13'd0, bh.A, bh.B, bh.C}, 16'd2);
        chk("single_multi", 16'(bh.multi), 16'd0);
        chk("single_pend", 16'(bh.pend_cnt), 16'd1);
        step();
        chk("single_done_valid", 16'(bh.valid), 16'd0);
        chk("single_done_busy", 16'(bh.busy), 16'd0);
        chk("single_done_pend", 16'(bh.pend_cnt), 16'd0);
        drain();
        step();

        // lines 7,5,2,0 back to back
        capture(8'hA5, 1'b1);
        chk("multi_flag_h", 16'(bh.multi), 16'd1);
        chk("multi_flag_l", 16'(bl.multi), 16'd1);
        serve_check(4);
        drain();
        step();

        // all eight lines under backpressure
        capture(8'hFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_abc_h", {13'd0, bh.A, bh.B, bh.C}, 16'd7);
            chk("bp_abc_l", {13'd0, bl.A, bl.B, bl.C}, 16'd0);
            chk("bp_pend", 16'(bh.pend_cnt), 16'd8);
            chk("bp_valid", 16'(bh.valid), 16'd1);
            step();
        end
        set_in(8'hFF, 1'b0, 1'b1);
        serve_check(8);
        drain();

        // enable low and no lines asserted
        set_in(8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("en0_valid", 16'(bh.valid), 16'd0);
        end
        set_in(8'hFF, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_valid", 16'(bh.valid), 16'd0);
            chk("idle_multi_kept", 16'(bh.multi), 16'd1);
        end

        // inputs ignored during SERVE, line 0 picked up after one idle cycle
        capture(8'h08, 1'b0);
        set_in(8'hFE, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ign_abc", {13'd0, bh.A, bh.B, bh.C}, 16'd3);
            chk("ign_pend", 16'(bh.pend_cnt), 16'd1);
        end
        set_in(8'hFE, 1'b1, 1'b1);
        step();
        chk("gap_valid", 16'(bh.valid), 16'd0);
        push_exp(8'h01);
        step();
        set_in(8'hFF, 1'b0, 1'b1);
        chk("recap_valid", 16'(bh.valid), 16'd1);
        chk("recap_abc", {13'd0, bh.A, bh.B, bh.C}, 16'd0);
        drain();
        step();

        // asynchronous reset in the middle of SERVE
        capture(8'hA5, 1'b1);
        step();
        chk("pre_rst_pend", 16'(bh.pend_cnt), 16'd3);
        #2 rst = 1'b1;
        qh.delete();
        ql.delete();
        #1;
        chk("arst_valid", 16'(bh.valid), 16'd0);
        chk("arst_pend", 16'(bh.pend_cnt), 16'd0);
        chk("arst_multi", 16'(bh.multi), 16'd0);
        chk("arst_busy_l", 16'(bl.busy), 16'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_valid", 16'(bh.valid | bl.valid), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
